// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: pipelined Urdhva-Tiryagbhyam multiplier, signed/unsigned per beat.
// Stage 1 registers operand magnitudes, then one Vedic recursion level per stage
// (2x2 cells folded into stage 2), final stage restores the sign.
// The whole pipe is one shift register gated by a single advance enable.
module vedic_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               In_Valid,
  output logic               In_Ready,
  input  logic [WIDTH-1:0]   In_1,
  input  logic [WIDTH-1:0]   In_2,
  input  logic               Sign,
  input  logic [TAG_W-1:0]   In_Tag,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  output logic [2*WIDTH-1:0] Result,
  output logic [TAG_W-1:0]   Out_Tag
);

  localparam int NLVL = $clog2(WIDTH);
  localparam int LAT  = NLVL + 1;
  localparam int PW   = 2 * WIDTH;

  logic advance;

  logic [WIDTH-1:0]            mag_a_d, mag_a_q, mag_b_d, mag_b_q;
  logic [LAT:1]                vld_pipe_d, vld_pipe_q;
  logic [LAT-1:1]              neg_pipe_d, neg_pipe_q;
  logic [LAT:1][TAG_W-1:0]     tag_pipe_d, tag_pipe_q;
  logic [PW-1:0]               result_d, result_q;
  logic [PW-1:0]               prod;

  // Whole pipe moves together; it only stalls when a result sits unconsumed.
  assign advance   = !vld_pipe_q[LAT] | Out_Ready;
  assign In_Ready  = advance & !Rst;
  assign Out_Valid = vld_pipe_q[LAT];
  assign Out_Tag   = tag_pipe_q[LAT];
  assign Result    = result_q;

  // Stage-1 magnitudes plus the valid/neg/tag shift registers.
  always_comb begin
    mag_a_d    = mag_a_q;
    mag_b_d    = mag_b_q;
    vld_pipe_d = vld_pipe_q;
    neg_pipe_d = neg_pipe_q;
    tag_pipe_d = tag_pipe_q;
    if (advance) begin
      // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
      mag_a_d       = (Sign && In_1[WIDTH-1]) ? -In_1 : In_1;
      mag_b_d       = (Sign && In_2[WIDTH-1]) ? -In_2 : In_2;
      vld_pipe_d[1] = In_Valid & In_Ready;
      neg_pipe_d[1] = Sign & (In_1[WIDTH-1] ^ In_2[WIDTH-1]);
      tag_pipe_d[1] = In_Tag;
      for (int s = 2; s <= LAT; s++) begin
        vld_pipe_d[s] = vld_pipe_q[s-1];
        tag_pipe_d[s] = tag_pipe_q[s-1];
      end
      for (int s = 2; s < LAT; s++) begin
        neg_pipe_d[s] = neg_pipe_q[s-1];
      end
    end
  end

  // Control and stage-1 state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      vld_pipe_q <= '0;
      neg_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      mag_a_q    <= mag_a_d;
      mag_b_q    <= mag_b_d;
      vld_pipe_q <= vld_pipe_d;
      neg_pipe_q <= neg_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  // Recursion levels. Level L holds every (digit_i x digit_j) product for 2^L-bit
  // digits, flattened as index i*N+j, each 2^(L+1) bits wide. Level 1 is the
  // combinational 2x2 cell array; each higher level is one registered stage.
  for (genvar L = 1; L <= NLVL; L++) begin : g_lvl
    localparam int B   = 1 << L;
    localparam int N   = WIDTH >> L;
    localparam int PB  = 2 * B;
    localparam int PPW = N * N * PB;

    logic [PPW-1:0] pp;

    if (L == 1) begin : g_cells
      for (genvar i = 0; i < N; i++) begin : g_i
        for (genvar j = 0; j < N; j++) begin : g_j
          vedic2x2 u_cell (
            .a (mag_a_q[2*i +: 2]),
            .b (mag_b_q[2*j +: 2]),
            .p (pp[(i*N+j)*4 +: 4])
          );
        end
      end
    end else begin : g_stage
      localparam int H  = B / 2;
      localparam int N2 = 2 * N;

      logic [PPW-1:0] pp_d, pp_q;

      // Vedic cross-add: vertical low, crosswise middle, vertical high.
      always_comb begin
        pp_d = pp_q;
        if (advance) begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
              pp_d[(i*N+j)*PB +: PB] =
                  PB'(g_lvl[L-1].pp[((2*i  )*N2 + 2*j  )*B +: B])
                + (PB'(g_lvl[L-1].pp[((2*i+1)*N2 + 2*j  )*B +: B]) << H)
                + (PB'(g_lvl[L-1].pp[((2*i  )*N2 + 2*j+1)*B +: B]) << H)
                + (PB'(g_lvl[L-1].pp[((2*i+1)*N2 + 2*j+1)*B +: B]) << B);
            end
          end
        end
      end

      // Recursion-level pipeline register.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) pp_q <= '0;
        else     pp_q <= pp_d;
      end

      assign pp = pp_q;
    end
  end

  // The top level has a single digit pair: the full unsigned product.
  assign prod = g_lvl[NLVL].pp;

  // Final stage re-applies the sign; the 2W-bit result never overflows.
  always_comb begin
    result_d = result_q;
    if (advance) result_d = neg_pipe_q[LAT-1] ? -prod : prod;
  end

  // Output register, held bit-for-bit while stalled.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) result_q <= '0;
    else     result_q <= result_d;
  end

endmodule

// vedic2x2: 2x2 Urdhva-Tiryagbhyam cell (vertical, crosswise, vertical).
module vedic2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic x10, x01, hi, c1;

  assign x10  = a[1] & b[0];
  assign x01  = a[0] & b[1];
  assign hi   = a[1] & b[1];
  assign c1   = x10 & x01;
  assign p[0] = a[0] & b[0];
  assign p[1] = x10 ^ x01;
  assign p[2] = hi ^ c1;
  assign p[3] = hi & c1;

endmodule
